// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback path.
package regfile_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 32;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic [1:0] req_i,
  input  wb_req_e    last_i,
  output logic [1:0] gnt_o
);

  // bit 0 = ALU, bit 1 = MEM
  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req_i == 2'b11): gnt_o = (last_i == WB_ALU) ? 2'b10 : 2'b01;
      (req_i == 2'b01): gnt_o = 2'b01;
      (req_i == 2'b10): gnt_o = 2'b10;
      default:          gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback.
// Option: REGFILE_WB_ZERO_PROTECT_EN makes register 0 unwritable.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_fwd,
  output logic              rt_fwd,
  output logic [CNT_W-1:0]  contention_count
);

  logic              write_q, write_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  wb_req_e           last_q, last_d;

  logic [1:0]        req, gnt;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              fwd_ok;

  // Requests are masked in reset so nothing is accepted and they stay held.
  assign req = {mem_valid, alu_valid} & {2{reset_n}};

  rr_arbiter2 u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];
  assign xfer      = |gnt;
  assign sel_addr  = gnt[1] ? mem_addr : alu_addr;
  assign sel_data  = gnt[1] ? mem_data : alu_data;

  always_comb begin
    write_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    if (xfer) begin
`ifdef REGFILE_WB_ZERO_PROTECT_EN
      write_d = (sel_addr != '0);
`else
      write_d = 1'b1;
`endif
      rd_addr_d = sel_addr;
      data_d    = sel_data;
      last_d    = gnt[1] ? WB_MEM : WB_ALU;
    end
    if (alu_valid && mem_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      write_q   <= 1'b0;
      rd_addr_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      last_q    <= WB_ALU;
    end else begin
      write_q   <= write_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

`ifdef REGFILE_WB_ZERO_PROTECT_EN
  assign fwd_ok = write_q && (rd_addr_q != '0);
`else
  assign fwd_ok = write_q;
`endif

  assign rs_fwd           = fwd_ok && (rd_addr_q == rs_addr);
  assign rt_fwd           = fwd_ok && (rd_addr_q == rt_addr);
  assign write            = write_q;
  assign rd_addr          = rd_addr_q;
  assign data_in          = data_q;
  assign contention_count = cnt_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter for the 64-entry register file. It shares the register file's single write port between two writeback sources: the ALU result path and the memory-load path. Arbitration is round-robin with a valid/ready handshake. The block drives the register file's `write`/`rd_addr`/`data_in` from one registered stage, and flags same-cycle read-after-write hazards on the rs/rt read addresses.

## Interface
Parameters:
- `ADDR_W`, 6, register address width (64 registers)
- `DATA_W`, 32, register data width
- `CNT_W`, 16, width of the contention counter

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `alu_valid`  in  1  ALU writeback request
- `alu_ready`  out  1  ALU request accepted this cycle
- `alu_addr`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `mem_valid`  in  1  load writeback request
- `mem_ready`  out  1  load request accepted this cycle
- `mem_addr`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load data
- `write`  out  1  register file write enable
- `rd_addr`  out  ADDR_W  register file write address
- `data_in`  out  DATA_W  register file write data
- `rs_addr`, `rt_addr`  in  ADDR_W  current decode-stage read addresses
- `rs_fwd`, `rt_fwd`  out  1  pending write matches rs/rt; use `data_in` instead of the register file output
- `contention_count`  out  CNT_W  saturating count of cycles with both requests valid

## Operation
- Handshake:
  - A requester raises valid with addr/data and holds all three stable until it sees ready high at a rising edge.
  - Transfer occurs on the edge where valid && ready.
  - Valid must not depend on ready.
- Ready is combinational from the valids and the `last_grant` flop. At most one ready is high per cycle.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to `last_grant` is granted.
  - No valid: no grant, and `last_grant` is unchanged.
- State: `last_grant` ∈ {ALU, MEM}, updated to the granted requester on every transfer.
- Output stage:
  - On a transfer, `write`←1, `rd_addr`←granted addr, `data_in`←granted data.
  - With no transfer, `write`←0 and `rd_addr`/`data_in` hold their previous values.
- Forwarding:
  - `rs_fwd` = `write` && (`rd_addr` == `rs_addr`); `rt_fwd` likewise for `rt_addr`. Both are combinational.
  - Both may be high together.
- Contention counter:
  - Increments on each edge where `alu_valid` && `mem_valid`.
  - Saturates at 2^CNT_W−1 with no wrap.
- Reset (`reset_n`=0 at an edge):
  - `write`=0, `rd_addr`=0, `data_in`=0, `contention_count`=0, `last_grant`=ALU, so MEM wins the first tie.
  - While `reset_n`=0, `alu_ready`=`mem_ready`=0. No transfer occurs and any in-flight request is held, not dropped.
  - A write already registered before reset is cancelled: `write` goes 0 on the reset edge.

## Timing
- Request-to-write latency:
  - Transfer at edge N gives `write`=1 with its addr/data during cycle N+1.
  - The register file captures the write at edge N+1.
- Throughput:
  - One write per cycle sustained.
  - Back-to-back transfers from the same requester are allowed when the other requester is idle.
- Under continuous contention, grants alternate every cycle. Maximum wait for any requester is 1 cycle.
- Ready is asserted in the same cycle as valid; there are no bubbles.
- `rs_fwd`/`rt_fwd` are valid during cycle N+1, the same cycle as the pending `write`.

## Configuration
- `REGFILE_WB_ZERO_PROTECT_EN` defined:
  - Requests to address 0 are still handshaken (ready, `last_grant` update) but never set `write`.
  - Address 0 never produces `rs_fwd`/`rt_fwd`.
  - Register 0 therefore keeps its reset value 0.
- Not defined: address 0 is an ordinary writable register.

## Structure
- Shared package `regfile_pkg`:
  - `REG_ADDR_W`=6 and `REG_DATA_W`=32 constants.
  - Typedef `wb_req_e` {`WB_ALU`, `WB_MEM`}, used for `last_grant`.
- One natural sub-module: `rr_arbiter2`, a 2-way round-robin grant (inputs: two requests and `last_grant`; outputs: one-hot grant).
- Output register, forwarding compares and the counter stay in the top module.

## Test plan
- Reset, then `alu_valid`=1, `alu_addr`=3, `alu_data`=19 → `alu_ready`=1 same cycle; next cycle `write`=1, `rd_addr`=3, `data_in`=19; cycle after, `write`=0.
- Both valid for 4 cycles after reset (ALU addr 2, MEM addr 4) → grants MEM, ALU, MEM, ALU; `contention_count`=4.
- ALU write to 5 accepted and `rs_addr`=5, `rt_addr`=5 in cycle N+1 → `rs_fwd`=`rt_fwd`=1; `rt_addr`=6 → `rt_fwd`=0.
- MEM request to addr 0 with data 0xDEADBEEF → with `REGFILE_WB_ZERO_PROTECT_EN`, `mem_ready`=1 but `write` stays 0; without it, `write`=1, `rd_addr`=0.
- `reset_n`=0 while `alu_valid`=1 and a write is pending → `write`=0 and `alu_ready`=0 during reset; after release the ALU request is accepted on the first cycle and MEM wins the next tie.
- Force `contention_count` near max (CNT_W=4, 20 contended cycles) → counter holds at 15.
